// File: rtl/fp_pack_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared floating-point definitions: rounding modes and
//                packed-word constant builders parametrised by field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rnd_mode_e;

    // Constant builders return a wide word; callers keep the low fp_width bits.
    localparam int FP_MAX_W = 64;

    function automatic int fp_width(input int exp_w, input int mant_w);
        return 1 + exp_w + mant_w;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int mant_w);
        logic [FP_MAX_W-1:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << mant_w;
        v = v | (64'd1 << (mant_w - 1));
        return v;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_w, input int mant_w);
        return ((64'd1 << exp_w) - 64'd1) << mant_w;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_max_finite(input int exp_w, input int mant_w);
        logic [FP_MAX_W-1:0] v;
        v = ((64'd1 << exp_w) - 64'd2) << mant_w;
        v = v | ((64'd1 << mant_w) - 64'd1);
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_pack_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pack_pipe_if
//  Description : Input beat and output result handshake bundle for the
//                multiplier pack pipeline. slave = pipeline, master = driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_pack_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
);
    localparam int PW = 2 * (MANT_W + 1);
    localparam int DW = 1 + EXP_W + MANT_W;

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sign;
    logic signed [EXP_W+1:0] in_exp;
    logic [PW-1:0]          in_prod;
    logic                   in_zero;
    logic                   in_inf;
    logic                   in_nan;
    logic [1:0]             rnd_mode;

    logic                   out_valid;
    logic                   out_ready;
    logic [DW-1:0]          out_data;
    logic                   out_ovf;
    logic                   out_unf;
    logic                   out_inx;

    modport master (
        output in_valid, in_sign, in_exp, in_prod, in_zero, in_inf, in_nan, rnd_mode,
        output out_ready,
        input  in_ready,
        input  out_valid, out_data, out_ovf, out_unf, out_inx
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_prod, in_zero, in_inf, in_nan, rnd_mode,
        input  out_ready,
        output in_ready,
        output out_valid, out_data, out_ovf, out_unf, out_inx
    );

endinterface
`default_nettype wire

// File: rtl/fp_pack_pipe_round.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round
//  Description : Combinational round-increment for a normalised significand,
//                shared between the multiplier and adder output stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                    sign_i,
    input  logic signed [EXP_W+1:0] exp_i,
    input  logic [MANT_W-1:0]       frac_i,
    input  logic                    guard_i,
    input  logic                    sticky_i,
    input  rnd_mode_e               mode_i,
    output logic signed [EXP_W+1:0] exp_o,
    output logic [MANT_W-1:0]       frac_o,
    output logic                    inexact_o
);

    localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);

    logic              w_incr;
    logic              w_lost;
    logic [MANT_W:0]   w_sum;

    assign w_lost = guard_i | sticky_i;

    always_comb begin
        w_incr = 1'b0;
        case (mode_i)
            RM_RNE:  w_incr = guard_i & (sticky_i | frac_i[0]);
            RM_RTZ:  w_incr = 1'b0;
            RM_RUP:  w_incr = ~sign_i & w_lost;
            RM_RDN:  w_incr = sign_i & w_lost;
            default: w_incr = 1'b0;
        endcase
    end

    // A carry out of the fraction means the significand became 2.0: the low
    // bits wrap to zero on their own, so only the exponent needs bumping.
    assign w_sum     = {1'b0, frac_i} + {{MANT_W{1'b0}}, w_incr};
    assign frac_o    = w_sum[MANT_W-1:0];
    assign exp_o     = w_sum[MANT_W] ? (exp_i + EXP_ONE) : exp_i;
    assign inexact_o = w_lost;

endmodule
`default_nettype wire

// File: rtl/fp_pack_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pack_pipe
//  Description : Two-stage normalise / round-and-pack output pipeline for the
//                floating-point multiplier with valid/ready backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_pack_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic           clk,
    input  logic           rst,
    fp_pack_pipe_if.slave  bus
);

    localparam int PW = 2 * (MANT_W + 1);
    localparam int DW = fp_width(EXP_W, MANT_W);
    localparam int XW = EXP_W + 2;

    localparam logic [FP_MAX_W-1:0] QNAN_WIDE = fp_qnan(EXP_W, MANT_W);
    localparam logic [FP_MAX_W-1:0] INF_WIDE  = fp_inf(EXP_W, MANT_W);
    localparam logic [FP_MAX_W-1:0] MAXF_WIDE = fp_max_finite(EXP_W, MANT_W);
    localparam logic [DW-1:0]       QNAN      = QNAN_WIDE[DW-1:0];
    localparam logic [DW-2:0]       INF_MAG   = INF_WIDE[DW-2:0];
    localparam logic [DW-2:0]       MAXF_MAG  = MAXF_WIDE[DW-2:0];

    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_OVF  = XW'((2 ** EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_can_load;
    logic w_in_ready;

    logic s1_valid_q;
    logic out_valid_q;

    assign w_s2_can_load = ~out_valid_q | bus.out_ready;
    assign w_in_ready    = ~s1_valid_q | w_s2_can_load;
    assign bus.in_ready  = w_in_ready;

    // ------------------------------------------------------------------
    // Stage 1: normalise into [1,2) and split fraction / guard / sticky
    // ------------------------------------------------------------------
    logic                 s1_exp_sel;
    logic signed [XW-1:0] s1_exp_d;
    logic [MANT_W-1:0]    s1_frac_d;
    logic                 s1_guard_d;
    logic                 s1_sticky_d;

    assign s1_exp_sel = bus.in_prod[PW-1];

    always_comb begin
        if (s1_exp_sel) begin
            s1_exp_d    = bus.in_exp + EXP_ONE;
            s1_frac_d   = bus.in_prod[PW-2 -: MANT_W];
            s1_guard_d  = bus.in_prod[PW-2-MANT_W];
            s1_sticky_d = |bus.in_prod[PW-3-MANT_W:0];
        end else begin
            s1_exp_d    = bus.in_exp;
            s1_frac_d   = bus.in_prod[PW-3 -: MANT_W];
            s1_guard_d  = bus.in_prod[PW-3-MANT_W];
            s1_sticky_d = |bus.in_prod[PW-4-MANT_W:0];
        end
    end

    logic                 s1_sign_q;
    logic signed [XW-1:0] s1_exp_q;
    logic [MANT_W-1:0]    s1_frac_q;
    logic                 s1_guard_q;
    logic                 s1_sticky_q;
    rnd_mode_e            s1_mode_q;
    logic                 s1_zero_q;
    logic                 s1_inf_q;
    logic                 s1_nan_q;

    // ------------------------------------------------------------------
    // Stage 2: round, range check, class override, pack
    // ------------------------------------------------------------------
    logic signed [XW-1:0] rnd_exp;
    logic [MANT_W-1:0]    rnd_frac;
    logic                 rnd_inx;

    fp_round #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_round (
        .sign_i    (s1_sign_q),
        .exp_i     (s1_exp_q),
        .frac_i    (s1_frac_q),
        .guard_i   (s1_guard_q),
        .sticky_i  (s1_sticky_q),
        .mode_i    (s1_mode_q),
        .exp_o     (rnd_exp),
        .frac_o    (rnd_frac),
        .inexact_o (rnd_inx)
    );

    logic          ovf_to_inf;
    logic [DW-1:0] out_data_d;
    logic          out_ovf_d;
    logic          out_unf_d;
    logic          out_inx_d;

    assign ovf_to_inf = (s1_mode_q == RM_RNE)
                      | ((s1_mode_q == RM_RUP) & ~s1_sign_q)
                      | ((s1_mode_q == RM_RDN) &  s1_sign_q);

    // Class flags win over any range outcome and never raise flags.
    always_comb begin
        out_data_d = {s1_sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
        out_ovf_d  = 1'b0;
        out_unf_d  = 1'b0;
        out_inx_d  = rnd_inx;
        if (s1_nan_q || (s1_inf_q && s1_zero_q)) begin
            out_data_d = QNAN;
            out_inx_d  = 1'b0;
        end else if (s1_inf_q) begin
            out_data_d = {s1_sign_q, INF_MAG};
            out_inx_d  = 1'b0;
        end else if (s1_zero_q) begin
            out_data_d = {s1_sign_q, {(DW-1){1'b0}}};
            out_inx_d  = 1'b0;
        end else if (rnd_exp >= EXP_OVF) begin
            out_data_d = ovf_to_inf ? {s1_sign_q, INF_MAG} : {s1_sign_q, MAXF_MAG};
            out_ovf_d  = 1'b1;
            out_inx_d  = 1'b1;
        end else if (rnd_exp <= EXP_ZERO) begin
            out_data_d = {s1_sign_q, {(DW-1){1'b0}}};
            out_unf_d  = 1'b1;
            out_inx_d  = 1'b1;
        end
    end

    logic [DW-1:0] out_data_q;
    logic          out_ovf_q;
    logic          out_unf_q;
    logic          out_inx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_frac_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_mode_q   <= RM_RNE;
            s1_zero_q   <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_nan_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
            out_inx_q   <= 1'b0;
        end else begin
            if (w_in_ready) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign_q   <= bus.in_sign;
                    s1_exp_q    <= s1_exp_d;
                    s1_frac_q   <= s1_frac_d;
                    s1_guard_q  <= s1_guard_d;
                    s1_sticky_q <= s1_sticky_d;
                    s1_mode_q   <= rnd_mode_e'(bus.rnd_mode);
                    s1_zero_q   <= bus.in_zero;
                    s1_inf_q    <= bus.in_inf;
                    s1_nan_q    <= bus.in_nan;
                end
            end
            // Output registers hold while stalled, keeping data and flags stable.
            if (w_s2_can_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= out_data_d;
                    out_ovf_q  <= out_ovf_d;
                    out_unf_q  <= out_unf_d;
                    out_inx_q  <= out_inx_d;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_unf   = out_unf_q;
    assign bus.out_inx   = out_inx_q;

endmodule
`default_nettype wire

// File: doc/fp_pack_pipe.md
# fp_pack_pipe

Parametrised two-stage output pipeline for the floating-point multiplier. It takes the raw significand product, the biased exponent sum and the sign. It normalises the product, rounds it under a selectable rounding mode, and resolves overflow, underflow and special operands. The result is packed into a {sign, exponent, fraction} word, and a valid/ready handshake allows the downstream consumer to stall the pipeline.

## Interface
- `EXP_W`, 8, exponent field width.
- `MANT_W`, 23, stored fraction width. Significand is MANT_W+1 bits; product width PW = 2*(MANT_W+1).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  stage 1 can accept a beat.
- `in_sign`  in  1  result sign.
- `in_exp`  in  EXP_W+2  signed biased exponent (ea+eb-bias), before normalisation.
- `in_prod`  in  PW  unsigned significand product; value in [1,4) with the binary point after bit PW-2.
- `in_zero`, `in_inf`, `in_nan`  in  1 each  operand class flags from upstream.
- `rnd_mode`  in  2  00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf). Sampled with the beat.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  1+EXP_W+MANT_W  packed result; MSB is the sign.
- `out_ovf`, `out_unf`, `out_inx`  out  1 each  overflow, underflow and inexact flags, aligned with `out_data`.

## Operation
- Stage 1 (normalise):
  - If `in_prod[PW-1]`=1: shift right by 1 and set exp = `in_exp`+1.
  - Fraction = the MANT_W bits below the leading one.
  - Guard bit = next bit down.
  - Sticky = OR of all remaining lower bits.
  - Register sign, exp, fraction, guard, sticky, mode and class flags.
- Stage 2 (round, check range, pack):
  - Increment decision:
    - RNE: guard & (sticky | lsb).
    - RTZ: 0.
    - RUP: !sign & (guard|sticky).
    - RDN: sign & (guard|sticky).
  - Rounding carry out of the fraction: fraction becomes 0 and exp increments.
  - inexact = guard|sticky.
- Range, applied after rounding:
  - Overflow: exp ≥ 2^EXP_W−1.
    - Result is ±inf for RNE, for RUP when sign=0 and for RDN when sign=1.
    - Otherwise result is ±max finite (exp=2^EXP_W−2, fraction all ones).
    - Set `out_ovf` and `out_inx`.
  - Underflow: exp ≤ 0. Flush to ±0 (no denormals); set `out_unf` and `out_inx`.
- Class precedence, overriding the range logic:
  - nan: quiet NaN (exp all ones, fraction MSB=1, sign 0).
  - inf & zero: quiet NaN.
  - inf: ±inf.
  - zero: ±0.
  - No flags are set for these results.
- Widths: exponent arithmetic is EXP_W+2 bits signed throughout. Only the low EXP_W bits are packed, and only for in-range results.

## Timing
- Latency is 2 cycles from input acceptance to `out_valid` when the pipeline is not stalled. Throughput is 1 beat/cycle.
- Handshakes:
  - Input transfer: `in_valid & in_ready`.
  - Output transfer: `out_valid & out_ready`.
  - `out_data` and the flags hold stable while `out_valid & !out_ready`.
- Each stage loads when it is empty or its contents move forward in the same cycle.
  - `in_ready` = !s1_valid | s2_can_load.
  - s2_can_load = !out_valid | out_ready.
  - `in_ready` depends combinationally on `out_ready`. This is accepted.
- Full pipeline with `out_ready` low: `in_ready`=0 and no beat is lost.
- Simultaneous accept and drain in the same cycle: both happen and no bubble is inserted.
- Reset (active-low assertion, any cycle):
  - All valids clear immediately and in-flight beats are discarded.
  - `out_data`=0 and all flags = 0.
  - `in_ready` goes to 1 once both stages are empty.

## Structure
- Shared package `fp_pkg`:
  - Rounding-mode encodings.
  - Functions for the packed-word width, qNaN, inf and max-finite constants, parametrised by EXP_W/MANT_W.
- Sub-module `fp_round`: combinational stage-2 rounding and increment logic, reusable by the adder's output stage.
- Top module: pipeline registers, handshake logic and the class-precedence mux.

## Test plan
- 1.5×1.5 (`in_prod`=0x900000000000, `in_exp`=127, RNE) → `out_data`=0x40100000, no flags, 2-cycle latency.
- Rounding carry, with all bits of `in_prod` from PW-2 down to PW-25 set, `in_prod[PW-1]`=0, guard=1, `in_exp`=127, RNE → 0x40000000, `out_inx`=1.
- `in_exp`=254 with product ≥2:
  - RNE → 0x7F800000, `out_ovf`=1.
  - Same beat, RTZ → 0x7F7FFFFF.
  - Same beat, sign=1, RUP → 0xFF7FFFFF.
- `in_exp`=0 with product <2, sign=1 → 0x80000000, `out_unf`=1, `out_inx`=1.
- `in_inf`=1 & `in_zero`=1 → 0x7FC00000, no flags. `in_zero` alone with sign=1 → 0x80000000.
- Backpressure and reset:
  - Stream 6 beats with `out_ready` toggling 1,0,0,1,… → all 6 results in order, stable while stalled, none dropped or duplicated.
  - Assert reset with 2 beats in flight → `out_valid`=0 and `out_data`=0 immediately.
